// File: rtl/region_fill.sv
// region_fill
//   Memory-region initialiser. On go it latches an address window
//   [region_begin, region_end) plus a fill mode, then writes one word per
//   memory handshake. The supported modes are zero, constant, and arithmetic
//   ramp. The block reports completion, abort, bad-window error and the
//   number of words written.
//
// Ports
//   clk, rst_l        clock, asynchronous active-low reset
//   go                level start; sampled in IDLE (start) and DONE (release)
//   abort             stop request, honoured at the next word boundary
//   mode              0 zero, 1 constant, 2 ramp, 3 treated as zero
//   fill_value, step  constant value / ramp base, ramp increment
//   region_begin/end  window, begin inclusive, end exclusive
//   mem_done          memory accepted the presented word
//   ptr, w_en, r_en, avail, data_store, write_through, read_through
//                     memory handle request fields (all registered)
//   done, aborted, error, words_written
//                     status; held in DONE and until the next start
module region_fill #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              go,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_value,
    input  logic [DATA_W-1:0] step,
    input  logic [ADDR_W-1:0] region_begin,
    input  logic [ADDR_W-1:0] region_end,
    input  logic              mem_done,
    output logic [ADDR_W-1:0] ptr,
    output logic              w_en,
    output logic              r_en,
    output logic              avail,
    output logic [DATA_W-1:0] data_store,
    output logic              write_through,
    output logic              read_through,
    output logic              done,
    output logic              aborted,
    output logic              error,
    output logic [ADDR_W-1:0] words_written
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state, state_nxt;

    // Run configuration captured at start
    logic [ADDR_W-1:0] end_lat, end_lat_nxt;
    logic [1:0]        mode_lat, mode_lat_nxt;
    logic [DATA_W-1:0] fill_lat, fill_lat_nxt;
    logic [DATA_W-1:0] step_lat, step_lat_nxt;

    // Ramp accumulator: fill_value + k*step for the word currently in flight
    logic [DATA_W-1:0] acc, acc_nxt;
    logic              abort_flag, abort_flag_nxt;

    logic [ADDR_W-1:0] ptr_nxt, words_nxt, ptr_inc;
    logic [DATA_W-1:0] data_nxt;
    logic              w_en_nxt, avail_nxt, wt_nxt;
    logic              done_nxt, aborted_nxt, error_nxt;

    function automatic logic [DATA_W-1:0] word_for_mode(
        input logic [1:0]        m,
        input logic [DATA_W-1:0] fv,
        input logic [DATA_W-1:0] ramp
    );
        case (m)
            2'd1:    return fv;
            2'd2:    return ramp;
            default: return '0;
        endcase
    endfunction

    assign r_en         = 1'b0;
    assign read_through = 1'b0;
    assign ptr_inc      = ptr + ADDR_W'(1);

    always_comb begin
        state_nxt      = state;
        end_lat_nxt    = end_lat;
        mode_lat_nxt   = mode_lat;
        fill_lat_nxt   = fill_lat;
        step_lat_nxt   = step_lat;
        acc_nxt        = acc;
        abort_flag_nxt = abort_flag;
        ptr_nxt        = ptr;
        words_nxt      = words_written;
        data_nxt       = data_store;
        w_en_nxt       = w_en;
        avail_nxt      = avail;
        wt_nxt         = write_through;
        done_nxt       = done;
        aborted_nxt    = aborted;
        error_nxt      = error;

        unique case (state)
            IDLE: begin
                if (go) begin
                    end_lat_nxt    = region_end;
                    mode_lat_nxt   = mode;
                    fill_lat_nxt   = fill_value;
                    step_lat_nxt   = step;
                    acc_nxt        = fill_value;
                    abort_flag_nxt = 1'b0;
                    ptr_nxt        = region_begin;
                    words_nxt      = '0;
                    aborted_nxt    = 1'b0;
                    error_nxt      = 1'b0;
                    if (region_begin > region_end) begin
                        error_nxt = 1'b1;
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else if (region_begin == region_end) begin
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        avail_nxt = 1'b1;
                        w_en_nxt  = 1'b1;
                        data_nxt  = word_for_mode(mode, fill_value, fill_value);
                        wt_nxt    = (region_begin == region_end - ADDR_W'(1));
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                if (abort) abort_flag_nxt = 1'b1;
                // The presented word stays up until the memory takes it.
                if (mem_done) begin
                    avail_nxt = 1'b0;
                    w_en_nxt  = 1'b0;
                    wt_nxt    = 1'b0;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (abort) abort_flag_nxt = 1'b1;
                ptr_nxt   = ptr_inc;
                words_nxt = words_written + ADDR_W'(1);
                acc_nxt   = acc + step_lat;
                // Finishing the region wins over a pending abort.
                if (ptr_inc == end_lat) begin
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end else if (abort_flag || abort) begin
                    done_nxt    = 1'b1;
                    aborted_nxt = 1'b1;
                    state_nxt   = DONE;
                end else begin
                    avail_nxt = 1'b1;
                    w_en_nxt  = 1'b1;
                    data_nxt  = word_for_mode(mode_lat, fill_lat, acc_nxt);
                    wt_nxt    = (ptr_inc == end_lat - ADDR_W'(1));
                    state_nxt = REQ;
                end
            end
            DONE: begin
                // go must drop before another run can start.
                if (!go) begin
                    done_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state         <= IDLE;
            end_lat       <= '0;
            mode_lat      <= '0;
            fill_lat      <= '0;
            step_lat      <= '0;
            acc           <= '0;
            abort_flag    <= 1'b0;
            ptr           <= '0;
            words_written <= '0;
            data_store    <= '0;
            w_en          <= 1'b0;
            avail         <= 1'b0;
            write_through <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            error         <= 1'b0;
        end else begin
            state         <= state_nxt;
            end_lat       <= end_lat_nxt;
            mode_lat      <= mode_lat_nxt;
            fill_lat      <= fill_lat_nxt;
            step_lat      <= step_lat_nxt;
            acc           <= acc_nxt;
            abort_flag    <= abort_flag_nxt;
            ptr           <= ptr_nxt;
            words_written <= words_nxt;
            data_store    <= data_nxt;
            w_en          <= w_en_nxt;
            avail         <= avail_nxt;
            write_through <= wt_nxt;
            done          <= done_nxt;
            aborted       <= aborted_nxt;
            error         <= error_nxt;
        end
    end

endmodule

// File: tb/tb_region_fill.sv
// tb_region_fill
//   Directed bench for region_fill: zero fill, ramp with wrap and a slow
//   memory, empty and inverted windows, abort, asynchronous reset mid-run
//   and the go release/restart rule.
module tb_region_fill;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        go;
    logic        abort;
    logic [1:0]  mode;
    logic [31:0] fill_value;
    logic [31:0] step;
    logic [31:0] region_begin;
    logic [31:0] region_end;
    logic        mem_done;
    logic [31:0] ptr;
    logic        w_en;
    logic        r_en;
    logic        avail;
    logic [31:0] data_store;
    logic        write_through;
    logic        read_through;
    logic        done;
    logic        aborted;
    logic        error;
    logic [31:0] words_written;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] wr_ptr[$];
    logic [31:0] wr_data[$];
    logic        wr_wt[$];
    int          avail_cycles;

    logic [31:0] ramp_exp [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

    always #5 clk = ~clk;

    region_fill #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .go            (go),
        .abort         (abort),
        .mode          (mode),
        .fill_value    (fill_value),
        .step          (step),
        .region_begin  (region_begin),
        .region_end    (region_end),
        .mem_done      (mem_done),
        .ptr           (ptr),
        .w_en          (w_en),
        .r_en          (r_en),
        .avail         (avail),
        .data_store    (data_store),
        .write_through (write_through),
        .read_through  (read_through),
        .done          (done),
        .aborted       (aborted),
        .error         (error),
        .words_written (words_written)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Acts as the memory: accepts each presented word after 'delay' wait
    // cycles, pulses abort on the first REQ cycle of word 'abort_word',
    // logs every handshake and returns the cycle count until done.
    task automatic run(input int delay, input int abort_word, output int cyc);
        int          wait_cnt;
        int          nwr;
        logic [31:0] hp;
        logic [31:0] hd;
        wait_cnt = 0;
        nwr      = 0;
        cyc      = 0;
        hp       = '0;
        hd       = '0;
        wr_ptr.delete();
        wr_data.delete();
        wr_wt.delete();
        avail_cycles = 0;
        while (!done && cyc < 300) begin
            abort = 1'b0;
            if (avail) begin
                avail_cycles++;
                if (wait_cnt == 0) begin
                    hp = ptr;
                    hd = data_store;
                end else begin
                    chk("hold_ptr", ptr, hp);
                    chk("hold_data", data_store, hd);
                end
                if (nwr == abort_word && wait_cnt == 0) abort = 1'b1;
                mem_done = (wait_cnt >= delay);
                if (mem_done) begin
                    wr_ptr.push_back(ptr);
                    wr_data.push_back(data_store);
                    wr_wt.push_back(write_through);
                    nwr++;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                mem_done = (delay == 0);
            end
            tick();
            cyc++;
        end
        abort    = 1'b0;
        mem_done = 1'b0;
        chk("run_done_reached", done, 1'b1);
    endtask

    initial begin
        int cyc;
        rst_l        = 1'b0;
        go           = 1'b0;
        abort        = 1'b0;
        mode         = 2'd0;
        fill_value   = '0;
        step         = '0;
        region_begin = '0;
        region_end   = '0;
        mem_done     = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_ptr", ptr, 0);
        chk("rst_flags", {w_en, r_en, avail, write_through, read_through, done, aborted, error}, 8'h00);
        chk("rst_data", data_store, 0);
        chk("rst_words", words_written, 0);
        rst_l = 1'b1;
        tick();

        // Zero fill 0x10..0x13, memory always ready; inputs disturbed after start
        mode         = 2'd0;
        fill_value   = 32'h1234_5678;
        region_begin = 32'h10;
        region_end   = 32'h14;
        mem_done     = 1'b1;
        go           = 1'b1;
        tick();
        chk("zero_start_avail", avail, 1'b1);
        chk("zero_start_wen", w_en, 1'b1);
        region_begin = 32'h99;
        region_end   = 32'h80;
        mode         = 2'd1;
        run(0, -1, cyc);
        chk("zero_done_cycles", cyc, 8);
        chk("zero_nwrites", wr_ptr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("zero_ptr", wr_ptr[i], 32'h10 + i);
            chk("zero_data", wr_data[i], 0);
            chk("zero_wt", wr_wt[i], (i == 3));
        end
        chk("zero_words", words_written, 4);
        chk("zero_status", {aborted, error}, 2'b00);

        // go held through DONE: no restart
        repeat (4) begin
            tick();
            chk("hold_go_done", done, 1'b1);
            chk("hold_go_noavail", avail, 1'b0);
        end
        chk("hold_go_words", words_written, 4);
        go = 1'b0;
        tick();
        chk("release_done_clear", done, 1'b0);
        chk("release_words_kept", words_written, 4);

        // Second full run after one low cycle; count re-cleared
        region_begin = 32'h10;
        region_end   = 32'h14;
        mode         = 2'd0;
        go           = 1'b1;
        tick();
        chk("rerun_words_cleared", words_written, 0);
        chk("rerun_avail", avail, 1'b1);
        run(0, -1, cyc);
        chk("rerun_nwrites", wr_ptr.size(), 4);
        chk("rerun_words", words_written, 4);
        go = 1'b0;
        tick();

        // Ramp with wrap, memory answers after 3 wait cycles per word
        mode         = 2'd2;
        fill_value   = 32'hFFFF_FFFE;
        step         = 32'h1;
        region_begin = 32'h100;
        region_end   = 32'h104;
        go           = 1'b1;
        tick();
        run(3, -1, cyc);
        chk("ramp_nwrites", wr_ptr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("ramp_ptr", wr_ptr[i], 32'h100 + i);
            chk("ramp_data", wr_data[i], ramp_exp[i]);
        end
        chk("ramp_avail_cycles", avail_cycles, 16);
        chk("ramp_done_cycles", cyc, 20);
        chk("ramp_words", words_written, 4);
        go = 1'b0;
        tick();

        // Empty window; abort here must be ignored
        region_begin = 32'h20;
        region_end   = 32'h20;
        abort        = 1'b1;
        go           = 1'b1;
        tick();
        abort = 1'b0;
        chk("empty_done", done, 1'b1);
        chk("empty_avail", avail, 1'b0);
        chk("empty_words", words_written, 0);
        chk("empty_status", {aborted, error}, 2'b00);
        go = 1'b0;
        tick();

        // Inverted window
        region_begin = 32'h30;
        region_end   = 32'h20;
        go           = 1'b1;
        tick();
        chk("err_done", done, 1'b1);
        chk("err_error", error, 1'b1);
        chk("err_avail", avail, 1'b0);
        tick();
        chk("err_no_write", avail, 1'b0);
        chk("err_words", words_written, 0);
        go = 1'b0;
        tick();

        // Constant fill over 8 words, abort during word 2 with memory stalled
        mode         = 2'd1;
        fill_value   = 32'hA5;
        region_begin = 32'h200;
        region_end   = 32'h208;
        go           = 1'b1;
        tick();
        chk("error_cleared", error, 1'b0);
        run(2, 2, cyc);
        chk("abort_nwrites", wr_ptr.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("abort_ptr", wr_ptr[i], 32'h200 + i);
            chk("abort_data", wr_data[i], 32'hA5);
            chk("abort_wt", wr_wt[i], 1'b0);
        end
        chk("abort_flag", aborted, 1'b1);
        chk("abort_words", words_written, 3);
        chk("abort_done_cycles", cyc, 12);
        go = 1'b0;
        tick();

        // Asynchronous reset while a word is presented
        region_begin = 32'h300;
        region_end   = 32'h310;
        go           = 1'b1;
        mem_done     = 1'b0;
        tick();
        tick();
        chk("mid_avail", avail, 1'b1);
        #2;
        rst_l = 1'b0;
        #1;
        chk("areset_flags", {w_en, avail, write_through, done, aborted, error}, 6'h00);
        chk("areset_ptr", ptr, 0);
        chk("areset_data", data_store, 0);
        chk("areset_words", words_written, 0);
        go = 1'b0;
        tick();
        rst_l = 1'b1;
        tick();
        chk("post_reset_idle", {avail, done}, 2'b00);

        // Fresh start from the new window: ramp 7, 10
        mode         = 2'd2;
        fill_value   = 32'd7;
        step         = 32'd3;
        region_begin = 32'h400;
        region_end   = 32'h402;
        go           = 1'b1;
        tick();
        chk("restart_ptr", ptr, 32'h400);
        run(0, -1, cyc);
        chk("restart_nwrites", wr_ptr.size(), 2);
        chk("restart_ptr1", wr_ptr[1], 32'h401);
        chk("restart_data0", wr_data[0], 32'd7);
        chk("restart_data1", wr_data[1], 32'd10);
        chk("restart_wt0", wr_wt[0], 1'b0);
        chk("restart_wt1", wr_wt[1], 1'b1);
        chk("restart_words", words_written, 2);
        go = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
